// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-queue constants and entry type
package fetch_pkg;

  localparam int          ENTRY_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Field order matches the {instr, pc} packing used by the queue storage.
  typedef struct packed {
    logic [ENTRY_W-1:0] instr;
    logic [ENTRY_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - fetch queue entry array, one write port, async read port
module fq_storage #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are never reset; validity is tracked by the queue's count.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between ROM fetch and decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instr,
  output logic [WIDTH-1:0]         out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] NOP_W    = WIDTH'(NOP_INSTR);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);

  // A full queue refuses pushes even when decode pops in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fq_storage #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_instr, in_pc}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign out_instr = out_valid ? head[2*WIDTH-1:WIDTH] : NOP_W;
  assign out_pc    = out_valid ? head[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_entry_t mq[$];

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = $urandom;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    chk("count",     64'(count),     64'(mq.size()));
    chk("out_instr", 64'(out_instr), 64'(mq.size() != 0 ? mq[0].instr : NOP_INSTR));
    chk("out_pc",    64'(out_pc),    64'(mq.size() != 0 ? mq[0].pc : 32'h0));
  endtask

  // Called just after a rising edge; checks outputs, then applies the edge to the model.
  task automatic step();
    bit do_push;
    bit do_pop;
    fetch_entry_t e;
    #2;
    check_outputs();
    do_push = in_valid && (mq.size() < DEPTH) && !flush;
    do_pop  = (mq.size() != 0) && out_ready && !flush;
    e.instr = in_instr;
    e.pc    = in_pc;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_instr", 64'(out_instr), 64'h13);
    chk("reset_count",     64'(count),     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: entry pushed into empty queue is invisible during the push cycle.
    drive(1, 32'h100, 0, 0);
    #1;
    chk("lat_push_cycle_valid", 64'(out_valid), 64'd0);
    step();
    chk("lat_after_valid", 64'(out_valid), 64'd1);
    chk("lat_after_pc",    64'(out_pc),    64'h100);
    drive(0, 0, 1, 0);
    step();

    // Reset mid-stream with three entries, observed before any clock edge.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(i * 4), 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    chk("rst_pre_count", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_count", 64'(count),     64'd0);
    chk("rst_async_ready", 64'(in_ready),  64'd1);
    chk("rst_async_instr", 64'(out_instr), 64'h13);
    mq.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill with first push right after reset release, reject fifth push, drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 0, 0);
      step();
    end
    chk("fill_count", 64'(count),    64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    drive(1, 32'h10, 0, 0);
    step();
    chk("fill_reject_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0);
      #1;
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      step();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Full with simultaneous push and pop: pop only.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(32'h40 + i * 4), 0, 0);
      step();
    end
    drive(1, 32'h80, 1, 0);
    step();
    chk("full_pp_count", 64'(count),    64'd3);
    chk("full_pp_ready", 64'(in_ready), 64'd1);
    chk("full_pp_head",  64'(out_pc),   64'h44);

    // Flush beats concurrent push and pop.
    drive(1, 32'h90, 1, 1);
    step();
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);

    // Steady streaming across pointer wraps.
    drive(1, 32'h0, 0, 0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 32'(i * 4), 1, 0);
      #1;
      chk("wrap_count", 64'(count),  64'd1);
      chk("wrap_pc",    64'(out_pc), 64'((i - 1) * 4));
      step();
    end
    drive(0, 0, 1, 0);
    step();

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      drive(bit'($urandom_range(0, 3) != 0), $urandom, bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 19) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction and PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the fetch stage presents an instruction this cycle.
REQ-006 SHALL have port in_instr, input, WIDTH, meaning the instruction word from ROM.
REQ-007 SHALL have port in_pc, input, WIDTH, meaning the PC of in_instr.
REQ-008 SHALL have port in_ready, output, 1, meaning the queue accepts a push; fetch uses it as PC-advance enable.
REQ-009 SHALL have port flush, input, 1, meaning redirect (branch taken): discard all queued entries.
REQ-010 SHALL have port out_valid, output, 1, meaning the head entry is valid for decode.
REQ-011 SHALL have port out_instr, output, WIDTH, meaning the head instruction.
REQ-012 SHALL have port out_pc, output, WIDTH, meaning the head PC.
REQ-013 SHALL have port out_ready, input, 1, meaning decode consumes the head this cycle.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, meaning the current occupancy.

Function
REQ-015 SHALL push {in_instr, in_pc} at a clock edge when in_valid && in_ready && !flush.
REQ-016 SHALL pop the head at a clock edge when out_valid && out_ready && !flush.
REQ-017 SHALL drive in_ready = (count < DEPTH) combinationally; when full, no push occurs even if a pop happens the same cycle (no full bypass).
REQ-018 SHALL drive out_valid = (count != 0) combinationally; no empty-to-output bypass, so a pushed entry is visible one cycle after the push edge.
REQ-019 SHALL present the head entry on out_instr/out_pc combinationally from storage while out_valid=1.
REQ-020 SHALL drive out_instr = NOP (32'h00000013, zero-extended/truncated to WIDTH) and out_pc = 0 while out_valid=0.
REQ-021 SHALL on simultaneous push and pop (not full, not empty) keep count unchanged and advance both pointers.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL on flush, at the next edge, set count and both pointers to 0; flush has priority over push and pop in that cycle.
REQ-024 SHALL preserve FIFO order: entries leave in the order they were pushed.
REQ-025 SHALL ignore in_instr/in_pc when in_valid=0 and never alter stored entries except by push.

Reset
REQ-026 SHALL on rst=1, immediately and independent of clk, clear count and pointers to 0, giving out_valid=0, in_ready=1, out_instr=NOP, out_pc=0, count=0.
REQ-027 SHALL on reset asserted mid-operation discard all entries; storage contents need not be cleared.
REQ-028 SHALL accept a push at the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take the NOP encoding constant and a fetch-entry struct typedef {instr, pc} from shared package fetch_pkg.
REQ-030 SHALL keep pointer/count control in fetch_queue and MAY place the storage array in one sub-module fq_storage (write port plus asynchronous read port).

Verification
REQ-031 SHALL cover reset: assert rst mid-stream with count=3 -> out_valid=0, count=0, in_ready=1, out_instr=32'h00000013 without waiting for a clock edge.
REQ-032 SHALL cover fill/drain: push PCs 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; a fifth push of PC 0x10 is rejected; draining yields 0x0,0x4,0x8,0xC in order.
REQ-033 SHALL cover full with simultaneous push and pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3, in_ready=1 next cycle.
REQ-034 SHALL cover latency: push into empty queue at edge N -> out_valid=1 with the pushed instr from after edge N; out_valid=0 throughout the push cycle itself.
REQ-035 SHALL cover flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> after the edge count=0, out_valid=0, the pushed entry is discarded.
REQ-036 SHALL cover wrap-around: 10 consecutive push/pop pairs with steady streaming -> count stays 1 and PCs emerge 0x0..0x24 in order across pointer wraps.
